// File: rtl/ram_copy_engine.sv
// ram_copy_engine: block copy/fill engine on a byte RAM with registered read.
// Copy reads one byte then writes it (2 cycles/byte); fill writes one byte per cycle.
module ram_copy_engine #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter logic [ADDR_W-1:0] MAX_ADDR = 16'hFFFF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              mode_i,
   input  logic [ADDR_W-1:0] src_addr_i,
   input  logic [ADDR_W-1:0] dst_addr_i,
   input  logic [ADDR_W-1:0] len_i,
   input  logic [DATA_W-1:0] fill_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic              en_w_ram_o,
   output logic [ADDR_W-1:0] w_ram_addr_o,
   output logic [DATA_W-1:0] w_ram_data_o,
   output logic [ADDR_W-1:0] r_ram_addr_o,
   input  logic [DATA_W-1:0] r_ram_data_i
);
   typedef enum logic [2:0] {IDLE, SETUP, RD, WR, DONE} state_t;
   localparam logic [ADDR_W:0] ONE = 1;
   state_t state, state_nx;
   logic mode, err, desc;
   logic [ADDR_W-1:0] cur_src, cur_dst, cnt, r_last;
   logic [DATA_W-1:0] fill;
   logic [ADDR_W:0] src_end, dst_end;
   logic chk_err, chk_desc;
   // During SETUP cur_src/cur_dst/cnt still hold the captured base addresses and length.
   always_comb begin
      src_end  = {1'b0, cur_src} + {1'b0, cnt} - ONE;
      dst_end  = {1'b0, cur_dst} + {1'b0, cnt} - ONE;
      chk_err  = (cnt != '0) && ((dst_end > {1'b0, MAX_ADDR}) || (!mode && (src_end > {1'b0, MAX_ADDR})));
      chk_desc = !mode && (cur_src < cur_dst) && ({1'b0, cur_dst} <= src_end);
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start_i ? SETUP : IDLE;
         SETUP:   state_nx = (chk_err || cnt == '0) ? DONE : (mode ? WR : RD);
         RD:      state_nx = WR;
         WR:      state_nx = (cnt == ADDR_W'(1)) ? DONE : (mode ? WR : RD);
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         mode    <= 1'b0;
         err     <= 1'b0;
         desc    <= 1'b0;
         cur_src <= '0;
         cur_dst <= '0;
         cnt     <= '0;
         r_last  <= '0;
         fill    <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (start_i) begin
               mode    <= mode_i;
               cur_src <= src_addr_i;
               cur_dst <= dst_addr_i;
               cnt     <= len_i;
               fill    <= fill_data_i;
            end
            SETUP: begin
               err  <= chk_err;
               desc <= chk_desc;
               if (chk_desc) begin
                  cur_src <= src_end[ADDR_W-1:0];
                  cur_dst <= dst_end[ADDR_W-1:0];
               end
            end
            RD: r_last <= cur_src;
            WR: begin
               cnt     <= cnt - ADDR_W'(1);
               cur_src <= desc ? cur_src - ADDR_W'(1) : cur_src + ADDR_W'(1);
               cur_dst <= desc ? cur_dst - ADDR_W'(1) : cur_dst + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end
   assign busy_o       = (state == SETUP) || (state == RD) || (state == WR);
   assign done_o       = state == DONE;
   assign err_o        = done_o && err;
   assign en_w_ram_o   = state == WR;
   assign w_ram_addr_o = en_w_ram_o ? cur_dst : '0;
   assign w_ram_data_o = en_w_ram_o ? (mode ? fill : r_ram_data_i) : '0;
   assign r_ram_addr_o = (state == RD) ? cur_src : r_last;
endmodule

// File: tb/tb_ram_copy_engine.sv
// tb_ram_copy_engine: vector table of transfers against a byte RAM model, plus
// busy-restart, mid-transfer reset and back-to-back start sequences.
module tb_ram_copy_engine;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
   logic [15:0] src = '0, dst = '0, len = '0;
   logic [7:0] fill = '0;
   logic busy, done, err, en_w;
   logic [15:0] w_addr, r_addr;
   logic [7:0] w_data, r_data;
   logic pre_we = 1'b0;
   logic [15:0] pre_a = '0;
   logic [7:0] pre_d = '0;
   logic [7:0] mem [65536] = '{default: 8'h00};
   int n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   ram_copy_engine dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
      .src_addr_i(src), .dst_addr_i(dst), .len_i(len), .fill_data_i(fill),
      .busy_o(busy), .done_o(done), .err_o(err), .en_w_ram_o(en_w),
      .w_ram_addr_o(w_addr), .w_ram_data_o(w_data), .r_ram_addr_o(r_addr),
      .r_ram_data_i(r_data)
   );

   // RAM: registered read, read data is 0 when a write happens in the same cycle
   always @(posedge clk) begin
      if (pre_we) mem[pre_a] <= pre_d;
      else if (en_w) mem[w_addr] <= w_data;
      r_data <= en_w ? 8'h00 : mem[r_addr];
   end

   typedef struct {
      logic mode;
      logic [15:0] src, dst, len;
      logic [7:0] fill;
      int exp_done, exp_err, exp_writes, exp_first, nchk;
      logic [15:0] chk_base;
      logic [47:0] exp_bytes;
   } vec_t;
   vec_t vecs [10];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic poke(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      pre_a = a; pre_d = d; pre_we = 1'b1;
      @(posedge clk);
      #1 pre_we = 1'b0;
   endtask

   // Returns at start edge + 1ns, i.e. sampling point of cycle 1 (SETUP)
   task automatic launch(input logic m, input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] l, input logic [7:0] f);
      @(negedge clk);
      mode = m; src = s; dst = d; len = l; fill = f; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Called at the cycle-1 sampling point; counts cycles until done_o
   task automatic wait_done(output int cyc, output int writes, output int first,
                            output int e, output int b);
      cyc = -1; writes = 0; first = -1; e = -1; b = -1;
      for (int c = 1; c <= 300; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         if (en_w) begin
            writes++;
            if (first < 0) first = c;
         end
         if (done) begin
            cyc = c; e = int'(err); b = int'(busy);
            return;
         end
      end
   endtask

   initial begin
      int cyc, wr, first, e, b, cnt;
      vecs[0] = '{1'b0, 16'h0010, 16'h0100, 16'd4, 8'h00, 10, 0, 4, 3, 4, 16'h0100, 48'h0000_4433_2211};
      vecs[1] = '{1'b0, 16'h0020, 16'h0022, 16'd4, 8'h00, 10, 0, 4, 3, 6, 16'h0020, 48'hA3A2_A1A0_A1A0};
      vecs[2] = '{1'b1, 16'h0000, 16'h0040, 16'd3, 8'h5A,  5, 0, 3, 2, 4, 16'h0040, 48'h0000_005A_5A5A};
      vecs[3] = '{1'b0, 16'h0010, 16'h0080, 16'd0, 8'h00,  2, 0, 0, -1, 1, 16'h0080, 48'h0};
      vecs[4] = '{1'b1, 16'h0000, 16'hFFFF, 16'd2, 8'h33,  2, 1, 0, -1, 2, 16'hFFFE, 48'hC2C1};
      vecs[5] = '{1'b0, 16'hFFFE, 16'h0200, 16'd2, 8'h00,  6, 0, 2, 3, 2, 16'h0200, 48'hC2C1};
      vecs[6] = '{1'b0, 16'hFFFF, 16'h0300, 16'd2, 8'h00,  2, 1, 0, -1, 1, 16'h0300, 48'h0};
      vecs[7] = '{1'b1, 16'h0000, 16'hFFFF, 16'd1, 8'h77,  3, 0, 1, 2, 2, 16'hFFFE, 48'h77C1};
      vecs[8] = '{1'b0, 16'h0022, 16'h0020, 16'd3, 8'h00,  8, 0, 3, 3, 6, 16'h0020, 48'hA3A2_A1A2_A1A0};
      vecs[9] = '{1'b0, 16'h0010, 16'h0014, 16'd4, 8'h00, 10, 0, 4, 3, 4, 16'h0014, 48'h0000_4433_2211};
      poke(16'h0010, 8'h11); poke(16'h0011, 8'h22); poke(16'h0012, 8'h33); poke(16'h0013, 8'h44);
      poke(16'h0020, 8'hA0); poke(16'h0021, 8'hA1); poke(16'h0022, 8'hA2); poke(16'h0023, 8'hA3);
      poke(16'h0024, 8'hEE); poke(16'h0025, 8'hEF); poke(16'hFFFE, 8'hC1); poke(16'hFFFF, 8'hC2);
      @(negedge clk);
      chk("rst busy", busy, 0); chk("rst done", done, 0); chk("rst err", err, 0);
      chk("rst en_w", en_w, 0); chk("rst w_addr", w_addr, 0); chk("rst w_data", w_data, 0);
      chk("rst r_addr", r_addr, 0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         launch(vecs[i].mode, vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].fill);
         chk($sformatf("v%0d busy setup", i), busy, 1);
         wait_done(cyc, wr, first, e, b);
         chk($sformatf("v%0d done cycle", i), cyc, vecs[i].exp_done);
         chk($sformatf("v%0d err", i), e, vecs[i].exp_err);
         chk($sformatf("v%0d busy at done", i), b, 0);
         chk($sformatf("v%0d writes", i), wr, vecs[i].exp_writes);
         chk($sformatf("v%0d first write", i), first, vecs[i].exp_first);
         @(negedge clk);
         for (int k = 0; k < vecs[i].nchk; k++)
            chk($sformatf("v%0d mem[%0h]", i, vecs[i].chk_base + 16'(k)),
                mem[vecs[i].chk_base + 16'(k)], vecs[i].exp_bytes[8*k +: 8]);
      end
      // start pulsed while busy must be ignored
      launch(1'b0, 16'h0010, 16'h0500, 16'd2, 8'h00);
      fork
         wait_done(cyc, wr, first, e, b);
         begin
            @(posedge clk); @(posedge clk);
            #2 mode = 1'b1; dst = 16'h0510; fill = 8'hBB; start = 1'b1;
            @(posedge clk);
            #2 start = 1'b0;
         end
      join
      chk("busy-start done cycle", cyc, 6);
      chk("busy-start writes", wr, 2);
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1 cnt += int'(busy) + int'(done);
      end
      chk("busy-start no restart", cnt, 0);
      chk("busy-start mem500", mem[16'h0500], 8'h11);
      chk("busy-start mem501", mem[16'h0501], 8'h22);
      chk("busy-start mem510", mem[16'h0510], 8'h00);
      // reset asserted in cycle 4 of a copy
      launch(1'b0, 16'h0010, 16'h0600, 16'd4, 8'h00);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort busy", busy, 0); chk("abort en_w", en_w, 0); chk("abort done", done, 0);
      chk("abort w_addr", w_addr, 0); chk("abort r_addr", r_addr, 0);
      rst = 1'b0;
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1 cnt += int'(done) + int'(en_w) + int'(busy);
      end
      chk("abort stays idle", cnt, 0);
      chk("abort mem600", mem[16'h0600], 8'h11);
      chk("abort mem601", mem[16'h0601], 8'h00);
      // back-to-back: start held high through DONE
      @(negedge clk);
      mode = 1'b1; dst = 16'h0700; len = 16'd2; fill = 8'h99; start = 1'b1;
      @(posedge clk);
      #1;
      wait_done(cyc, wr, first, e, b);
      chk("b2b first done cycle", cyc, 4);
      dst = 16'h0702; fill = 8'h98;
      @(posedge clk);
      #1 chk("b2b idle busy", busy, 0);
      @(posedge clk);
      #1 chk("b2b second setup busy", busy, 1);
      start = 1'b0;
      wait_done(cyc, wr, first, e, b);
      chk("b2b second done cycle", cyc, 4);
      chk("b2b second writes", wr, 2);
      @(negedge clk);
      chk("b2b mem701", mem[16'h0701], 8'h99);
      chk("b2b mem702", mem[16'h0702], 8'h98);
      chk("b2b mem703", mem[16'h0703], 8'h98);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
